hms_ctrl_sync: RTL and testbench
================================

// Module: hms_ctrl_sync
// PURPOSE
//  Fully synchronous controller for the MM:SS clock/alarm datapath. Debounces the four
//  push-buttons, runs the CLOCK/SETUP/ALARM mode FSM and issues single-cycle increment
//  enables to the time and alarm counters, all on clk, with no derived clocks.
//  Sits between the board switches and the sec/min/alarm counters; mode/position feed display muxing.
// PARAMETERS
//  CLK_HZ     50_000_000  clk frequency; 1 Hz tick period in cycles
//  DEB_DIV    500_000     cycles between debounce samples (100 Hz at 50 MHz)
//  DEB_LEN    2           consecutive equal samples required to accept a level (>=2)
//  TIMEOUT_S  30          idle seconds in SETUP/ALARM before auto-return to CLOCK
// PORTS
//  clk              in   1  system clock, all logic on rising edge
//  rst_n            in   1  asynchronous active-low reset
//  i_sw0..i_sw3     in   1  raw buttons, active-low (0 = pressed): mode, position, increment, alarm-enable
//  i_sec_wrap       in   1  1-cycle pulse from seconds counter when it wraps 59->0
//  o_mode           out  2  00 CLOCK, 01 SETUP, 10 ALARM
//  o_position       out  1  0 SEC field, 1 MIN field
//  o_alarm_en       out  1  alarm armed
//  o_tick_1hz       out  1  1-cycle pulse every CLK_HZ cycles
//  o_sec_inc        out  1  1-cycle increment enable, time seconds
//  o_min_inc        out  1  1-cycle increment enable, time minutes
//  o_alm_sec_inc    out  1  1-cycle increment enable, alarm seconds
//  o_alm_min_inc    out  1  1-cycle increment enable, alarm minutes
// BEHAVIOUR
//  Reset: all outputs 0; mode CLOCK; position SEC; debounced levels = released(1); counters 0.
//  Tick: free-running counter 0..CLK_HZ-1; o_tick_1hz high in cycle where counter==CLK_HZ-1.
//  Debounce strobe: counter 0..DEB_DIV-1, strobe at DEB_DIV-1.
//  Debounce per switch: 2-flop synchroniser on clk; on each strobe shift sample into DEB_LEN-deep
//   history; stable level updates only when all DEB_LEN samples agree. Press event = stable level
//   1->0; 1-cycle internal pulse. Release generates no event. Holding a button yields one event.
//  Mode FSM (sw0 press): CLOCK->SETUP->ALARM->CLOCK. Encoding 11 unreachable; if seen -> CLOCK.
//   Every mode change forces position to SEC and clears idle counter.
//  sw1 press: toggle position in SETUP/ALARM; ignored in CLOCK.
//  sw2 press: SETUP -> o_sec_inc or o_min_inc per position; ALARM -> o_alm_sec_inc or
//   o_alm_min_inc per position; ignored in CLOCK.
//  sw3 press: toggle o_alarm_en in any mode.
//  Timekeeping: CLOCK and ALARM -> o_sec_inc on tick, o_min_inc on i_sec_wrap. SETUP -> tick and
//   i_sec_wrap ignored (time frozen), only sw2 increments.
//  Idle timeout: in SETUP/ALARM count ticks since last press event of any switch; at TIMEOUT_S
//   ticks go to CLOCK, position SEC. Counter held at 0 in CLOCK.
//  Latency: every o_*_inc, o_mode, o_position, o_alarm_en registered, 1 cycle after the causing
//   event/tick/i_sec_wrap. o_tick_1hz is itself registered. All inc outputs 1 cycle wide.
//  Simultaneous events, same cycle:
//   - sw0 with sw1/sw2: sw0 wins; sw1/sw2 discarded.
//   - sw1 with sw2: increment uses old position; position toggles afterwards.
//   - timeout expiry with any press: press wins; idle counter cleared, no timeout.
//   - SETUP sw2 on SEC with i_sec_wrap: only the sw2 increment issued.
//   - ALARM tick and sw2: o_sec_inc and o_alm_*_inc both pulse (independent).
//  Reset mid-press or mid-timeout: all state returns to reset values; a button held through reset
//   release produces one press event once debounced (level starts at released).
// TESTING (sim params CLK_HZ=100, DEB_DIV=10, DEB_LEN=2, TIMEOUT_S=3)
//  1 Reset, no input 1000 cycles -> o_tick_1hz every 100 cycles, o_sec_inc 1 cycle later, mode 00.
//  2 sw0 low 60 cycles then high -> exactly one mode step 00->01; 5 ns glitch on sw0 -> no change.
//  3 SETUP, position SEC, three sw2 presses -> three o_sec_inc pulses, zero tick-driven pulses;
//    sw1 press then sw2 -> one o_min_inc.
//  4 ALARM, position MIN, sw2 press -> one o_alm_min_inc; o_sec_inc continues every 100 cycles;
//    i_sec_wrap pulse -> o_min_inc 1 cycle later.
//  5 SETUP idle 3 ticks -> mode 00, position 0; press at 3rd tick cycle -> stays SETUP.
//  6 sw0 and sw2 press same cycle in SETUP -> mode 10, no inc; sw3 press -> o_alarm_en 0->1;
//    rst_n low mid-sequence -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/hms_ctrl_sync.sv
// MM:SS clock/alarm controller: button debounce, CLOCK/SETUP/ALARM mode FSM and
// single-cycle increment enables for the time and alarm counters, all on clk.
//
//  state      | meaning
//  MODE_CLOCK | time runs from tick / i_sec_wrap, buttons other than mode and alarm-enable ignored
//  MODE_SETUP | time frozen, sw2 increments the selected time field, idle timeout armed
//  MODE_ALARM | time runs, sw2 increments the selected alarm field, idle timeout armed
module hms_ctrl_sync #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int DEB_DIV   = 500_000,
    parameter int DEB_LEN   = 2,
    parameter int TIMEOUT_S = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_sw0,
    input  logic       i_sw1,
    input  logic       i_sw2,
    input  logic       i_sw3,
    input  logic       i_sec_wrap,
    output logic [1:0] o_mode,
    output logic       o_position,
    output logic       o_alarm_en,
    output logic       o_tick_1hz,
    output logic       o_sec_inc,
    output logic       o_min_inc,
    output logic       o_alm_sec_inc,
    output logic       o_alm_min_inc
);
    localparam int TW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int DW = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
    localparam int IW = $clog2(TIMEOUT_S + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(CLK_HZ - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_DIV - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_S - 1);

    typedef enum logic [1:0] {
        MODE_CLOCK = 2'b00,
        MODE_SETUP = 2'b01,
        MODE_ALARM = 2'b10
    } mode_e;

    logic [TW-1:0] tick_cnt_q;
    logic [DW-1:0] deb_cnt_q;
    logic          tick_q;
    logic          strobe;

    logic [3:0]              sw_raw;
    logic [3:0]              sync1_q, sync2_q;
    logic [3:0][DEB_LEN-1:0] hist_q;
    logic [3:0]              level_q, level_d;
    logic [3:0]              press;

    mode_e         mode_q, mode_d;
    logic          pos_q, pos_d;
    logic          alm_en_q, alm_en_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          sec_inc_q, sec_inc_d;
    logic          min_inc_q, min_inc_d;
    logic          alm_sec_inc_q, alm_sec_inc_d;
    logic          alm_min_inc_q, alm_min_inc_d;

    assign sw_raw = {i_sw3, i_sw2, i_sw1, i_sw0};
    assign strobe = (deb_cnt_q == DEB_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
            deb_cnt_q  <= '0;
            tick_q     <= 1'b0;
        end else begin
            tick_cnt_q <= (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + TW'(1);
            deb_cnt_q  <= strobe ? '0 : deb_cnt_q + DW'(1);
            tick_q     <= (tick_cnt_q == TICK_LAST);
        end
    end

    // A level is accepted only once the whole sample history agrees; a press is
    // the cycle in which an all-pressed history meets a still-released level.
    always_comb begin
        level_d = level_q;
        press   = '0;
        for (int i = 0; i < 4; i++) begin
            if (hist_q[i] == '0) begin
                level_d[i] = 1'b0;
                press[i]   = level_q[i];
            end else if (hist_q[i] == '1) begin
                level_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
            hist_q  <= '1;
            level_q <= '1;
        end else begin
            sync1_q <= sw_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            if (strobe) begin
                for (int i = 0; i < 4; i++) begin
                    hist_q[i] <= {hist_q[i][DEB_LEN-2:0], sync2_q[i]};
                end
            end
        end
    end

    always_comb begin
        mode_d        = mode_q;
        pos_d         = pos_q;
        alm_en_d      = alm_en_q;
        idle_d        = idle_q;
        sec_inc_d     = 1'b0;
        min_inc_d     = 1'b0;
        alm_sec_inc_d = 1'b0;
        alm_min_inc_d = 1'b0;

        if (mode_q != MODE_SETUP) begin
            sec_inc_d = tick_q;
            min_inc_d = i_sec_wrap;
        end
        if (press[2] && !press[0]) begin
            if (mode_q == MODE_SETUP) begin
                if (pos_q) min_inc_d = 1'b1;
                else       sec_inc_d = 1'b1;
            end else if (mode_q == MODE_ALARM) begin
                if (pos_q) alm_min_inc_d = 1'b1;
                else       alm_sec_inc_d = 1'b1;
            end
        end
        if (press[3]) alm_en_d = ~alm_en_q;

        if (press[0]) begin
            pos_d  = 1'b0;
            idle_d = '0;
            case (mode_q)
                MODE_CLOCK: mode_d = MODE_SETUP;
                MODE_SETUP: mode_d = MODE_ALARM;
                default:    mode_d = MODE_CLOCK;
            endcase
        end else begin
            case (mode_q)
                MODE_SETUP, MODE_ALARM: begin
                    if (press != '0) begin
                        idle_d = '0;
                        if (press[1]) pos_d = ~pos_q;
                    end else if (tick_q) begin
                        if (idle_q == IDLE_LAST) begin
                            mode_d = MODE_CLOCK;
                            pos_d  = 1'b0;
                            idle_d = '0;
                        end else begin
                            idle_d = idle_q + IW'(1);
                        end
                    end
                end
                default: begin
                    mode_d = MODE_CLOCK;
                    pos_d  = 1'b0;
                    idle_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q        <= MODE_CLOCK;
            pos_q         <= 1'b0;
            alm_en_q      <= 1'b0;
            idle_q        <= '0;
            sec_inc_q     <= 1'b0;
            min_inc_q     <= 1'b0;
            alm_sec_inc_q <= 1'b0;
            alm_min_inc_q <= 1'b0;
        end else begin
            mode_q        <= mode_d;
            pos_q         <= pos_d;
            alm_en_q      <= alm_en_d;
            idle_q        <= idle_d;
            sec_inc_q     <= sec_inc_d;
            min_inc_q     <= min_inc_d;
            alm_sec_inc_q <= alm_sec_inc_d;
            alm_min_inc_q <= alm_min_inc_d;
        end
    end

    assign o_mode        = mode_q;
    assign o_position    = pos_q;
    assign o_alarm_en    = alm_en_q;
    assign o_tick_1hz    = tick_q;
    assign o_sec_inc     = sec_inc_q;
    assign o_min_inc     = min_inc_q;
    assign o_alm_sec_inc = alm_sec_inc_q;
    assign o_alm_min_inc = alm_min_inc_q;

endmodule

// File: tb/tb_hms_ctrl_sync.sv
// Bench for hms_ctrl_sync: cycle-level behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized button/wrap traffic.
module tb_hms_ctrl_sync;
    localparam int CLK_HZ    = 100;
    localparam int DEB_DIV   = 10;
    localparam int DEB_LEN   = 2;
    localparam int TIMEOUT_S = 3;

    logic clk, rst_n;
    logic [3:0] sw_dir, sw_rnd, sw_eff;
    logic wrap_dir, wrap_rnd, wrap_eff;
    logic [1:0] o_mode;
    logic o_position, o_alarm_en, o_tick_1hz;
    logic o_sec_inc, o_min_inc, o_alm_sec_inc, o_alm_min_inc;

    int checks = 0;
    int errors = 0;
    int rnd_rate = 0;

    assign sw_eff   = sw_dir & sw_rnd;
    assign wrap_eff = wrap_dir | wrap_rnd;

    hms_ctrl_sync #(
        .CLK_HZ(CLK_HZ), .DEB_DIV(DEB_DIV), .DEB_LEN(DEB_LEN), .TIMEOUT_S(TIMEOUT_S)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_sw0(sw_eff[0]), .i_sw1(sw_eff[1]), .i_sw2(sw_eff[2]), .i_sw3(sw_eff[3]),
        .i_sec_wrap(wrap_eff),
        .o_mode(o_mode), .o_position(o_position), .o_alarm_en(o_alarm_en),
        .o_tick_1hz(o_tick_1hz), .o_sec_inc(o_sec_inc), .o_min_inc(o_min_inc),
        .o_alm_sec_inc(o_alm_sec_inc), .o_alm_min_inc(o_alm_min_inc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    int         m_tcnt, m_dcnt, m_idle, m_mode;
    logic       m_pos, m_alm, m_tick;
    logic [3:0] m_inc;             // {sec, min, alm_sec, alm_min}
    logic [3:0] m_dly1, m_dly2, m_lvl;
    logic       m_run_val [4];
    int         m_run_len [4];

    task automatic model_reset();
        m_tcnt = 0; m_dcnt = 0; m_idle = 0; m_mode = 0;
        m_pos = 1'b0; m_alm = 1'b0; m_tick = 1'b0; m_inc = '0;
        m_dly1 = '1; m_dly2 = '1; m_lvl = '1;
        for (int i = 0; i < 4; i++) begin
            m_run_val[i] = 1'b1;
            m_run_len[i] = DEB_LEN;
        end
    endtask

    task automatic model_step(input logic [3:0] raw, input logic wrap);
        logic [3:0] press;
        logic tick_now, strobe;
        press    = '0;
        tick_now = (m_tcnt == CLK_HZ - 1);
        strobe   = (m_dcnt == DEB_DIV - 1);
        for (int i = 0; i < 4; i++) begin
            if (m_run_len[i] >= DEB_LEN) begin
                if (!m_run_val[i] && m_lvl[i]) press[i] = 1'b1;
                m_lvl[i] = m_run_val[i];
            end
        end
        m_inc = '0;
        if (m_mode != 1) begin
            m_inc[3] = m_tick;
            m_inc[2] = wrap;
        end
        if (press[2] && !press[0]) begin
            if (m_mode == 1) begin
                if (m_pos) m_inc[2] = 1'b1; else m_inc[3] = 1'b1;
            end else if (m_mode == 2) begin
                if (m_pos) m_inc[0] = 1'b1; else m_inc[1] = 1'b1;
            end
        end
        if (press[3]) m_alm = !m_alm;
        if (press[0]) begin
            m_mode = (m_mode + 1) % 3; m_pos = 1'b0; m_idle = 0;
        end else if (m_mode == 0) begin
            m_idle = 0;
        end else if (press != 0) begin
            m_idle = 0;
            if (press[1]) m_pos = !m_pos;
        end else if (m_tick) begin
            m_idle++;
            if (m_idle >= TIMEOUT_S) begin
                m_mode = 0; m_pos = 1'b0; m_idle = 0;
            end
        end
        if (strobe) begin
            for (int i = 0; i < 4; i++) begin
                if (m_dly2[i] == m_run_val[i]) begin
                    if (m_run_len[i] < DEB_LEN) m_run_len[i]++;
                end else begin
                    m_run_val[i] = m_dly2[i];
                    m_run_len[i] = 1;
                end
            end
        end
        m_dly2 = m_dly1;
        m_dly1 = raw;
        m_tick = tick_now;
        m_tcnt = (m_tcnt + 1) % CLK_HZ;
        m_dcnt = (m_dcnt + 1) % DEB_DIV;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step(sw_eff, wrap_eff);
        end
    end

    // ---------------- per-cycle comparison ----------------
    logic [9:0] dut_vec, exp_vec;
    assign dut_vec = {o_mode, o_position, o_alarm_en, o_tick_1hz,
                      o_sec_inc, o_min_inc, o_alm_sec_inc, o_alm_min_inc};

    initial begin
        forever begin
            @(negedge clk);
            exp_vec = {2'(m_mode), m_pos, m_alm, m_tick, m_inc};
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++;
                $display("FAIL model_cmp t=%0t actual=%b required=%b", $time, dut_vec, exp_vec);
            end
        end
    end

    // ---------------- random drivers ----------------
    initial begin
        sw_rnd   = '1;
        wrap_rnd = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rnd_rate > 0) begin
                for (int i = 0; i < 4; i++)
                    if ($urandom_range(rnd_rate - 1, 0) == 0) sw_rnd[i] = ~sw_rnd[i];
                wrap_rnd = ($urandom_range(39, 0) == 0);
            end else begin
                sw_rnd   = '1;
                wrap_rnd = 1'b0;
            end
        end
    end

    // ---------------- directed helpers ----------------
    int c_tick, c_sec, c_min, c_asec, c_amin;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (o_tick_1hz)    c_tick++;
        if (o_sec_inc)     c_sec++;
        if (o_min_inc)     c_min++;
        if (o_alm_sec_inc) c_asec++;
        if (o_alm_min_inc) c_amin++;
    endtask

    task automatic clr_counts();
        c_tick = 0; c_sec = 0; c_min = 0; c_asec = 0; c_amin = 0;
    endtask

    task automatic press(input logic [3:0] mask, input int hold);
        #1 sw_dir = sw_dir & ~mask;
        repeat (hold) step();
        #1 sw_dir = '1;
        repeat (40) step();
    endtask

    initial begin
        int first_tick, first_sec, n;
        rst_n = 1'b0; sw_dir = '1; wrap_dir = 1'b0;
        clr_counts();
        repeat (3) step();
        check("reset_outputs", 32'(dut_vec), 0);
        #1 rst_n = 1'b1;

        // 1: free-running tick and clock-mode seconds
        first_tick = 0; first_sec = 0;
        for (int i = 1; i <= 1000; i++) begin
            step();
            if (o_tick_1hz && first_tick == 0) first_tick = i;
            if (o_sec_inc && first_sec == 0)   first_sec = i;
        end
        check("first_tick_cycle", first_tick, 100);
        check("first_sec_inc_cycle", first_sec, 101);
        check("tick_count_1000", c_tick, 10);
        check("sec_inc_count_1000", c_sec, 9);
        check("mode_clock", o_mode, 0);

        // 2: one mode step per held press; short glitch ignored
        press(4'b0001, 60);
        check("mode_setup", o_mode, 1);
        @(posedge clk);
        #1 sw_dir[0] = 1'b0;
        #5 sw_dir[0] = 1'b1;
        repeat (50) step();
        check("glitch_no_change", o_mode, 1);

        // 3: SETUP increments only from sw2
        clr_counts();
        repeat (3) press(4'b0100, 40);
        check("setup_sec_incs", c_sec, 3);
        check("setup_no_min_inc", c_min, 0);
        clr_counts();
        press(4'b0010, 40);
        check("setup_pos_min", o_position, 1);
        press(4'b0100, 40);
        check("setup_min_inc", c_min, 1);
        check("setup_sec_after_pos", c_sec, 0);

        // 4: ALARM field increments alongside running time
        press(4'b0001, 40);
        check("mode_alarm", o_mode, 2);
        check("alarm_pos_reset", o_position, 0);
        press(4'b0010, 40);
        clr_counts();
        press(4'b0100, 40);
        check("alm_min_inc", c_amin, 1);
        check("alm_sec_none", c_asec, 0);
        #1 wrap_dir = 1'b1;
        step();
        check("wrap_min_inc", o_min_inc, 1);
        #1 wrap_dir = 1'b0;
        step();
        check("wrap_min_inc_width", o_min_inc, 0);
        clr_counts();
        repeat (100) step();
        check("alarm_sec_per_100", c_sec, 1);

        // 5: idle timeout, and a press on the expiring tick defeats it
        repeat (400) step();
        check("alarm_timeout_mode", o_mode, 0);
        press(4'b0001, 40);
        repeat (350) step();
        check("setup_timeout_mode", o_mode, 0);
        check("setup_timeout_pos", o_position, 0);
        press(4'b0001, 40);
        n = 0;
        while (!(m_idle == 2 && m_tcnt == 85) && n < 400) begin
            step();
            n++;
        end
        check("align_wait_bound", 32'(n < 400), 1);
        #1 sw_dir[1] = 1'b0;
        repeat (40) step();
        #1 sw_dir[1] = 1'b1;
        repeat (10) step();
        check("press_at_expiry_mode", o_mode, 1);
        check("press_at_expiry_pos", o_position, 1);

        // 6: sw0 beats sw2, alarm enable, async reset, hold through reset
        clr_counts();
        press(4'b0101, 40);
        check("sw0_wins_mode", o_mode, 2);
        check("sw0_wins_no_min", c_min, 0);
        check("sw0_wins_no_alm", c_asec + c_amin, 0);
        press(4'b1000, 40);
        check("alarm_en_on", o_alarm_en, 1);
        step();
        #3 rst_n = 1'b0;
        #1 check("async_reset", 32'(dut_vec), 0);
        sw_dir[0] = 1'b0;
        repeat (5) step();
        #1 rst_n = 1'b1;
        repeat (60) step();
        #1 sw_dir[0] = 1'b1;
        repeat (40) step();
        check("held_through_reset", o_mode, 1);
        check("alarm_en_cleared", o_alarm_en, 0);

        // randomized traffic
        rnd_rate = 60;
        repeat (8000) step();
        rnd_rate = 300;
        repeat (6000) step();
        #3 rst_n = 1'b0;
        repeat (2) step();
        #1 rst_n = 1'b1;
        repeat (6000) step();
        rnd_rate = 0;
        repeat (100) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
